heq_master_sequencer: RTL and testbench

Master sequencer for the histogram equalizer core. Runs one frame through three phases in order: histogram, CDF, then divide/map. It drives the per-phase start levels and generates `input_mem_read_finished`. It also multiplexes the single shared scratch memory write/read-address port among the three engines, and a per-phase watchdog traps stalled engines.

---
 rtl/heq_master_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_heq_master_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heq_master_sequencer.sv
// Frame sequencer for the histogram equalizer: steps HIST -> CDF -> DIV, owns the
// shared scratch-memory port, and traps engines that stall with a per-phase watchdog.
`timescale 1ns/1ps
module heq_master_sequencer #(
    parameter int          PHASE_TIMEOUT   = 1000000,
    parameter int          TO_W            = 20,
    parameter logic [15:0] LAST_INPUT_ADDR = 16'd16383
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
    input  logic           abort,
    input  logic           input_mem_loaded,
    input  logic [15:0]    hist_input_raddr,
    input  logic           histogram_computation_done,
    input  logic           cdf_done,
    input  logic           divider_done,
    output logic           start_histogram,
    output logic           start_cdf,
    output logic           start_divider,
    output logic           input_mem_read_finished,
    input  logic           hist_sc_WE,
    input  logic [15:0]    hist_sc_waddr,
    input  logic [127:0]   hist_sc_wdata,
    input  logic [15:0]    hist_sc_raddr0,
    input  logic [15:0]    hist_sc_raddr1,
    input  logic           cdf_sc_WE,
    input  logic [15:0]    cdf_sc_waddr,
    input  logic [127:0]   cdf_sc_wdata,
    input  logic [15:0]    cdf_sc_raddr0,
    input  logic [15:0]    cdf_sc_raddr1,
    input  logic           div_sc_WE,
    input  logic [15:0]    div_sc_waddr,
    input  logic [127:0]   div_sc_wdata,
    input  logic [15:0]    div_sc_raddr0,
    input  logic [15:0]    div_sc_raddr1,
    output logic           sc_WE,
    output logic [15:0]    sc_waddr,
    output logic [127:0]   sc_wdata,
    output logic [15:0]    sc_raddr0,
    output logic [15:0]    sc_raddr1,
    output logic           busy,
    output logic           frame_done,
    output logic           error,
    output logic [1:0]     error_code,
    output logic           illegal_write,
    output logic [2:0]     phase
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIST  = 3'd1,
        S_CDF   = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HIST = 2'd1,
        OWN_CDF  = 2'd2,
        OWN_DIV  = 2'd3
    } owner_t;

    state_t            state;
    state_t            next_state;
    owner_t            owner;
    owner_t            next_owner;
    logic [TO_W-1:0]   wdog;
    logic [TO_W-1:0]   next_wdog;
    logic [1:0]        next_code;
    logic              next_rf;
    logic [2:0]        next_start;
    logic              in_phase;
    logic              phase_done;
    logic              timed_out;

    assign in_phase  = (state == S_HIST) || (state == S_CDF) || (state == S_DIV);
    assign timed_out = in_phase && (wdog == TO_W'(PHASE_TIMEOUT - 1));

    always_comb begin
        phase_done = 1'b0;
        case (state)
            S_HIST:  phase_done = histogram_computation_done;
            S_CDF:   phase_done = cdf_done;
            S_DIV:   phase_done = divider_done;
            default: phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Abort beats a done flag, which beats the watchdog.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (go && input_mem_loaded) next_state = S_HIST;
                S_HIST:  if (phase_done) next_state = S_CDF;
                         else if (timed_out) next_state = S_ERROR;
                S_CDF:   if (phase_done) next_state = S_DIV;
                         else if (timed_out) next_state = S_ERROR;
                S_DIV:   if (phase_done) next_state = S_DONE;
                         else if (timed_out) next_state = S_ERROR;
                S_DONE:  next_state = S_IDLE;
                S_ERROR: next_state = S_ERROR;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        next_start = {next_state == S_DIV, next_state == S_CDF, next_state == S_HIST};
        case (next_state)
            S_HIST:  next_owner = OWN_HIST;
            S_CDF:   next_owner = OWN_CDF;
            S_DIV:   next_owner = OWN_DIV;
            default: next_owner = OWN_NONE;
        endcase
        next_wdog = '0;
        if (in_phase && (next_state == state)) next_wdog = wdog + TO_W'(1);
        next_code = error_code;
        if (abort) next_code = 2'd0;
        else if ((next_state == S_ERROR) && (state != S_ERROR)) next_code = state[1:0];
        next_rf = (state == S_HIST) && (next_state == S_HIST) &&
                  (input_mem_read_finished || (hist_input_raddr == LAST_INPUT_ADDR));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_histogram         <= 1'b0;
            start_cdf               <= 1'b0;
            start_divider           <= 1'b0;
            owner                   <= OWN_NONE;
            wdog                    <= '0;
            error_code              <= 2'd0;
            input_mem_read_finished <= 1'b0;
        end else begin
            start_histogram         <= next_start[0];
            start_cdf               <= next_start[1];
            start_divider           <= next_start[2];
            owner                   <= next_owner;
            wdog                    <= next_wdog;
            error_code              <= next_code;
            input_mem_read_finished <= next_rf;
        end
    end

    // Sticky: any write enable from an engine that does not own the port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_write <= 1'b0;
        end else if ((hist_sc_WE && (owner != OWN_HIST)) ||
                     (cdf_sc_WE  && (owner != OWN_CDF))  ||
                     (div_sc_WE  && (owner != OWN_DIV))) begin
            illegal_write <= 1'b1;
        end
    end

    always_comb begin
        sc_WE     = 1'b0;
        sc_waddr  = '0;
        sc_wdata  = '0;
        sc_raddr0 = '0;
        sc_raddr1 = '0;
        case (owner)
            OWN_HIST: begin
                sc_WE     = hist_sc_WE;
                sc_waddr  = hist_sc_waddr;
                sc_wdata  = hist_sc_wdata;
                sc_raddr0 = hist_sc_raddr0;
                sc_raddr1 = hist_sc_raddr1;
            end
            OWN_CDF: begin
                sc_WE     = cdf_sc_WE;
                sc_waddr  = cdf_sc_waddr;
                sc_wdata  = cdf_sc_wdata;
                sc_raddr0 = cdf_sc_raddr0;
                sc_raddr1 = cdf_sc_raddr1;
            end
            OWN_DIV: begin
                sc_WE     = div_sc_WE;
                sc_waddr  = div_sc_waddr;
                sc_wdata  = div_sc_wdata;
                sc_raddr0 = div_sc_raddr0;
                sc_raddr1 = div_sc_raddr1;
            end
            default: ;
        endcase
    end

    assign busy       = in_phase;
    assign frame_done = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign phase      = state;

endmodule

// File: tb/tb_heq_master_sequencer.sv
// Bench for heq_master_sequencer: table-driven vectors, hand-written corner sequences
// and randomized traffic, all compared every cycle against a phase-level reference model.
`timescale 1ns/1ps
module tb_heq_master_sequencer;

    localparam int          PT   = 600;
    localparam logic [15:0] LAST = 16'd16383;

    logic clock, reset, go, abort, input_mem_loaded;
    logic [15:0] hist_input_raddr;
    logic histogram_computation_done, cdf_done, divider_done;
    logic start_histogram, start_cdf, start_divider, input_mem_read_finished;
    logic hist_sc_WE, cdf_sc_WE, div_sc_WE;
    logic [15:0] hist_sc_waddr, cdf_sc_waddr, div_sc_waddr;
    logic [127:0] hist_sc_wdata, cdf_sc_wdata, div_sc_wdata;
    logic [15:0] hist_sc_raddr0, cdf_sc_raddr0, div_sc_raddr0;
    logic [15:0] hist_sc_raddr1, cdf_sc_raddr1, div_sc_raddr1;
    logic sc_WE;
    logic [15:0] sc_waddr, sc_raddr0, sc_raddr1;
    logic [127:0] sc_wdata;
    logic busy, frame_done, error, illegal_write;
    logic [1:0] error_code;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, cycles spent in the phase so far (entry cycle = 1).
    int m_phase, m_cnt, m_code;
    bit m_rf, m_ill;
    int n_phase, n_cnt, n_code;
    bit n_rf, n_ill;

    typedef struct {
        logic       go;
        logic       loaded;
        logic       hd;
        logic       cd;
        logic       dd;
        logic       ab;
        logic [2:0] exp_phase;
        logic [2:0] exp_start;
        logic       exp_fd;
    } vec_t;

    vec_t vecs[16];

    heq_master_sequencer #(.PHASE_TIMEOUT(PT), .TO_W(10), .LAST_INPUT_ADDR(LAST)) dut (
        .clock(clock), .reset(reset), .go(go), .abort(abort),
        .input_mem_loaded(input_mem_loaded), .hist_input_raddr(hist_input_raddr),
        .histogram_computation_done(histogram_computation_done),
        .cdf_done(cdf_done), .divider_done(divider_done),
        .start_histogram(start_histogram), .start_cdf(start_cdf), .start_divider(start_divider),
        .input_mem_read_finished(input_mem_read_finished),
        .hist_sc_WE(hist_sc_WE), .hist_sc_waddr(hist_sc_waddr), .hist_sc_wdata(hist_sc_wdata),
        .hist_sc_raddr0(hist_sc_raddr0), .hist_sc_raddr1(hist_sc_raddr1),
        .cdf_sc_WE(cdf_sc_WE), .cdf_sc_waddr(cdf_sc_waddr), .cdf_sc_wdata(cdf_sc_wdata),
        .cdf_sc_raddr0(cdf_sc_raddr0), .cdf_sc_raddr1(cdf_sc_raddr1),
        .div_sc_WE(div_sc_WE), .div_sc_waddr(div_sc_waddr), .div_sc_wdata(div_sc_wdata),
        .div_sc_raddr0(div_sc_raddr0), .div_sc_raddr1(div_sc_raddr1),
        .sc_WE(sc_WE), .sc_waddr(sc_waddr), .sc_wdata(sc_wdata),
        .sc_raddr0(sc_raddr0), .sc_raddr1(sc_raddr1),
        .busy(busy), .frame_done(frame_done), .error(error), .error_code(error_code),
        .illegal_write(illegal_write), .phase(phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int modelOwner();
        return (m_phase >= 1 && m_phase <= 3) ? m_phase : 0;
    endfunction

    task automatic modelReset();
        m_phase = 0; m_cnt = 0; m_code = 0; m_rf = 0; m_ill = 0;
    endtask

    task automatic modelPredict();
        bit done;
        int own;
        own = modelOwner();
        n_phase = m_phase; n_cnt = 0; n_code = m_code; n_ill = m_ill;
        if ((hist_sc_WE && own != 1) || (cdf_sc_WE && own != 2) || (div_sc_WE && own != 3))
            n_ill = 1;
        if (abort) begin
            n_phase = 0;
            n_code  = 0;
        end else if (m_phase == 0) begin
            if (go && input_mem_loaded) n_phase = 1;
        end else if (m_phase <= 3) begin
            done = (m_phase == 1) ? histogram_computation_done :
                   (m_phase == 2) ? cdf_done : divider_done;
            if (done) n_phase = m_phase + 1;
            else if (m_cnt == PT) begin
                n_phase = 5;
                n_code  = m_phase;
            end else n_cnt = m_cnt + 1;
        end else if (m_phase == 4) begin
            n_phase = 0;
        end
        if (n_phase >= 1 && n_phase <= 3 && n_phase != m_phase) n_cnt = 1;
        n_rf = (m_phase == 1) && (n_phase == 1) && (m_rf || hist_input_raddr == LAST);
    endtask

    task automatic checkOutput();
        int own;
        logic e_we;
        logic [15:0] e_wa, e_r0, e_r1;
        logic [127:0] e_wd;
        own = modelOwner();
        e_we = 0; e_wa = 0; e_r0 = 0; e_r1 = 0; e_wd = 0;
        if (own == 1) begin
            e_we = hist_sc_WE; e_wa = hist_sc_waddr; e_wd = hist_sc_wdata;
            e_r0 = hist_sc_raddr0; e_r1 = hist_sc_raddr1;
        end else if (own == 2) begin
            e_we = cdf_sc_WE; e_wa = cdf_sc_waddr; e_wd = cdf_sc_wdata;
            e_r0 = cdf_sc_raddr0; e_r1 = cdf_sc_raddr1;
        end else if (own == 3) begin
            e_we = div_sc_WE; e_wa = div_sc_waddr; e_wd = div_sc_wdata;
            e_r0 = div_sc_raddr0; e_r1 = div_sc_raddr1;
        end
        chk("phase", 128'(phase), 128'(m_phase));
        chk("start_histogram", 128'(start_histogram), 128'(m_phase == 1));
        chk("start_cdf", 128'(start_cdf), 128'(m_phase == 2));
        chk("start_divider", 128'(start_divider), 128'(m_phase == 3));
        chk("busy", 128'(busy), 128'(m_phase >= 1 && m_phase <= 3));
        chk("frame_done", 128'(frame_done), 128'(m_phase == 4));
        chk("error", 128'(error), 128'(m_phase == 5));
        chk("error_code", 128'(error_code), 128'(m_code));
        chk("read_finished", 128'(input_mem_read_finished), 128'(m_rf));
        chk("illegal_write", 128'(illegal_write), 128'(m_ill));
        chk("sc_WE", 128'(sc_WE), 128'(e_we));
        chk("sc_waddr", 128'(sc_waddr), 128'(e_wa));
        chk("sc_wdata", sc_wdata, e_wd);
        chk("sc_raddr0", 128'(sc_raddr0), 128'(e_r0));
        chk("sc_raddr1", 128'(sc_raddr1), 128'(e_r1));
    endtask

    task automatic tick();
        modelPredict();
        @(posedge clock);
        #1;
        m_phase = n_phase; m_cnt = n_cnt; m_code = n_code; m_rf = n_rf; m_ill = n_ill;
        checkOutput();
    endtask

    task automatic randData();
        hist_sc_waddr = 16'($urandom); cdf_sc_waddr = 16'($urandom); div_sc_waddr = 16'($urandom);
        hist_sc_raddr0 = 16'($urandom); cdf_sc_raddr0 = 16'($urandom); div_sc_raddr0 = 16'($urandom);
        hist_sc_raddr1 = 16'($urandom); cdf_sc_raddr1 = 16'($urandom); div_sc_raddr1 = 16'($urandom);
        hist_sc_wdata = {$urandom, $urandom, $urandom, $urandom};
        cdf_sc_wdata  = {$urandom, $urandom, $urandom, $urandom};
        div_sc_wdata  = {$urandom, $urandom, $urandom, $urandom};
        hist_sc_WE = (modelOwner() == 1) && ($urandom_range(1) == 1);
        cdf_sc_WE  = (modelOwner() == 2) && ($urandom_range(1) == 1);
        div_sc_WE  = (modelOwner() == 3) && ($urandom_range(1) == 1);
    endtask

    task automatic applyStimulus(input logic g, input logic ld, input logic h,
                                 input logic c, input logic d, input logic a);
        go = g; input_mem_loaded = ld; histogram_computation_done = h;
        cdf_done = c; divider_done = d; abort = a;
        randData();
        tick();
    endtask

    task automatic resetDut();
        reset = 1'b0;
        go = 0; abort = 0; input_mem_loaded = 0; hist_input_raddr = 0;
        histogram_computation_done = 0; cdf_done = 0; divider_done = 0;
        hist_sc_WE = 0; cdf_sc_WE = 0; div_sc_WE = 0;
        #2;
        modelReset();
        checkOutput();
        chk("reset_phase", 128'(phase), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_start_div", 128'(start_divider), 128'(0));
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 3'd0, 3'b000, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0};
        vecs[3]  = '{0, 1, 0, 1, 0, 0, 3'd1, 3'b001, 0};
        vecs[4]  = '{0, 1, 1, 0, 0, 0, 3'd2, 3'b010, 0};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 3'd2, 3'b010, 0};
        vecs[6]  = '{0, 1, 0, 1, 0, 0, 3'd3, 3'b100, 0};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 3'd3, 3'b100, 0};
        vecs[8]  = '{0, 1, 0, 0, 1, 0, 3'd4, 3'b000, 1};
        vecs[9]  = '{1, 1, 0, 0, 0, 0, 3'd0, 3'b000, 0};
        vecs[10] = '{1, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 1, 3'd0, 3'b000, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 0, 3'd1, 3'b001, 0};
        vecs[13] = '{0, 1, 1, 0, 0, 0, 3'd2, 3'b010, 0};
        vecs[14] = '{0, 1, 0, 1, 0, 1, 3'd0, 3'b000, 0};
        vecs[15] = '{1, 1, 0, 0, 0, 1, 3'd0, 3'b000, 0};

        #3;
        resetDut();

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].go, vecs[i].loaded, vecs[i].hd, vecs[i].cd, vecs[i].dd, vecs[i].ab);
            chk($sformatf("vec%0d_phase", i), 128'(phase), 128'(vecs[i].exp_phase));
            chk($sformatf("vec%0d_start", i), 128'({start_divider, start_cdf, start_histogram}),
                128'(vecs[i].exp_start));
            chk($sformatf("vec%0d_frame_done", i), 128'(frame_done), 128'(vecs[i].exp_fd));
        end

        // Normal frame with the input-address ramp hitting the last word at cycle 50.
        for (int c = 0; c <= 902; c++) begin
            hist_input_raddr = 16'(16333 + c);
            applyStimulus(c == 10, 1, c == 200, c == 460, c == 900, 0);
            case (c)
                10:  chk("frame_hist_entry", 128'(phase), 128'(1));
                49:  chk("frame_rf_early", 128'(input_mem_read_finished), 128'(0));
                50:  chk("frame_rf_set", 128'(input_mem_read_finished), 128'(1));
                199: chk("frame_rf_held", 128'(input_mem_read_finished), 128'(1));
                200: begin
                    chk("frame_cdf_entry", 128'(phase), 128'(2));
                    chk("frame_rf_clear", 128'(input_mem_read_finished), 128'(0));
                end
                460: chk("frame_div_entry", 128'(phase), 128'(3));
                900: chk("frame_done_pulse", 128'(frame_done), 128'(1));
                901: chk("frame_idle", 128'(phase), 128'(0));
                default: ;
            endcase
        end
        hist_input_raddr = 0;

        // Non-owner write during HIST must be blocked and flagged.
        applyStimulus(1, 1, 0, 0, 0, 0);
        hist_sc_WE = 0; hist_sc_waddr = 16'h1234;
        cdf_sc_WE = 1; cdf_sc_waddr = 16'h0040;
        #1;
        chk("illegal_blocked_we", 128'(sc_WE), 128'(0));
        chk("illegal_hist_addr", 128'(sc_waddr), 128'(16'h1234));
        tick();
        chk("illegal_set", 128'(illegal_write), 128'(1));
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 0);
        chk("illegal_sticky", 128'(illegal_write), 128'(1));
        applyStimulus(0, 1, 0, 0, 0, 1);
        chk("illegal_survives_abort", 128'(illegal_write), 128'(1));
        resetDut();

        // Watchdog in each phase: ERROR exactly PT cycles after entry, abort clears code.
        for (int p = 1; p <= 3; p++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            for (int q = 1; q < p; q++) applyStimulus(0, 1, q == 1, q == 2, 0, 0);
            for (int k = 1; k < PT; k++) applyStimulus(0, 1, 0, 0, 0, 0);
            chk($sformatf("to%0d_still_in_phase", p), 128'(phase), 128'(p));
            applyStimulus(0, 1, 0, 0, 0, 0);
            chk($sformatf("to%0d_error", p), 128'(phase), 128'(5));
            chk($sformatf("to%0d_code", p), 128'(error_code), 128'(p));
            applyStimulus(1, 1, 0, 0, 0, 0);
            chk($sformatf("to%0d_held", p), 128'(error), 128'(1));
            applyStimulus(0, 1, 0, 0, 0, 1);
            chk($sformatf("to%0d_abort_idle", p), 128'(phase), 128'(0));
            chk($sformatf("to%0d_abort_code", p), 128'(error_code), 128'(0));
        end

        // divider_done on the timeout cycle: done wins.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        for (int k = 1; k < PT; k++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        chk("coincide_done", 128'(phase), 128'(4));
        chk("coincide_code", 128'(error_code), 128'(0));
        applyStimulus(1, 1, 0, 0, 0, 0);
        chk("coincide_idle", 128'(phase), 128'(0));

        // Reset mid-DIV without a clock edge.
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        chk("pre_reset_div", 128'(phase), 128'(3));
        resetDut();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            hist_input_raddr = ($urandom_range(9) == 0) ? LAST : 16'($urandom);
            applyStimulus($urandom_range(7) == 0, $urandom_range(3) != 0,
                          $urandom_range(19) == 0, $urandom_range(19) == 0,
                          $urandom_range(19) == 0, $urandom_range(99) == 0);
            if (k == 2500) resetDut();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
